// File: rtl/timer_regs_pkg.sv
// Register map, control bits and sequencer state encoding for the interval timer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package timer_regs_pkg;

  // Timer register word addresses
  localparam logic [2:0] TMR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_PERIOD_H = 3'd3;

  // Control register bit positions
  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  // Control words: run continuously with interrupt, and halt
  localparam logic [15:0] CTRL_GO   = 16'((1 << ITO) | (1 << CONT) | (1 << START));
  localparam logic [15:0] CTRL_HALT = 16'(1 << STOP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_RUN,
    S_CLR,
    S_GAP,
    S_WR_STOP
  } state_t;

endpackage

// File: rtl/timer_tick_sequencer.sv
// Programs the interval timer on start, services each timeout as a tick, stops on limit/abort.
// Latency: config writes 1..3 cycles after start; tick 1 cycle after irq seen; stop write 1 cycle after decision.
// Backpressure: none; timer bus has no waitrequest, start while busy is dropped, stop always wins.
module timer_tick_sequencer
  import timer_regs_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       cfg_period,
  input  logic [TICK_W-1:0] tick_limit,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic              tmr_irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              done,
  output logic              busy,
  output logic              cfg_err
);

  state_t            state_q, state_d;
  logic [31:0]       period_q;
  logic [31:0]       period_src;
  logic [TICK_W-1:0] limit_q;
  logic              start_ok;
  logic              start_bad;
  logic              limit_hit;
  logic              wr_d;
  logic [2:0]        addr_d;
  logic [15:0]       data_d;

  assign start_ok   = (state_q == S_IDLE) && start && (cfg_period != 32'd0);
  assign start_bad  = (state_q == S_IDLE) && start && (cfg_period == 32'd0);
  // The period write happens on the same edge that captures the config, so use the live input then.
  assign period_src = start_ok ? cfg_period : period_q;
  // Limit check after the increment has landed; an abort in GAP suppresses done.
  assign limit_hit  = (state_q == S_GAP) && !stop && (limit_q != '0) && (tick_count == limit_q);

  // Next-state: config writes, wait for irq, clear/tick, limit check, stop write
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_WR_PL;
      S_WR_PL:   state_d = stop ? S_WR_STOP : S_WR_PH;
      S_WR_PH:   state_d = stop ? S_WR_STOP : S_WR_CTRL;
      S_WR_CTRL: state_d = stop ? S_WR_STOP : S_RUN;
      S_RUN:     state_d = stop ? S_WR_STOP : (tmr_irq ? S_CLR : S_RUN);
      S_CLR:     state_d = stop ? S_WR_STOP : S_GAP;
      S_GAP:     state_d = (stop || limit_hit) ? S_WR_STOP : S_RUN;
      S_WR_STOP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Bus word for the state being entered, so the registered bus matches the current state
  always_comb begin
    wr_d   = 1'b0;
    addr_d = TMR_STATUS;
    data_d = 16'h0000;
    case (state_d)
      S_WR_PL:   begin wr_d = 1'b1; addr_d = TMR_PERIOD_L; data_d = period_src[15:0];  end
      S_WR_PH:   begin wr_d = 1'b1; addr_d = TMR_PERIOD_H; data_d = period_src[31:16]; end
      S_WR_CTRL: begin wr_d = 1'b1; addr_d = TMR_CONTROL;  data_d = CTRL_GO;           end
      S_CLR:     begin wr_d = 1'b1; addr_d = TMR_STATUS;   data_d = 16'h0000;          end
      S_WR_STOP: begin wr_d = 1'b1; addr_d = TMR_CONTROL;  data_d = CTRL_HALT;         end
      default:   ;
    endcase
  end

  // State, config capture, tick counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      period_q       <= '0;
      limit_q        <= '0;
      tmr_address    <= TMR_STATUS;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= '0;
      tick           <= 1'b0;
      tick_count     <= '0;
      done           <= 1'b0;
      busy           <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_address    <= addr_d;
      tmr_chipselect <= wr_d;
      tmr_write_n    <= !wr_d;
      tmr_writedata  <= data_d;
      tick           <= (state_d == S_CLR);
      done           <= limit_hit;
      busy           <= (state_d != S_IDLE);
      cfg_err        <= start_bad;
      if (start_ok) begin
        period_q   <= cfg_period;
        limit_q    <= tick_limit;
        tick_count <= '0;
      end else if (state_d == S_CLR) begin
        tick_count <= tick_count + TICK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer_tick_sequencer.sv
// Self-checking bench: behavioural interval timer plus event logs checked per scenario.
// Latency: n/a.
// Backpressure: n/a.
module tb_timer_tick_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [31:0] cfg_period;
  logic [3:0]  tick_limit;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;
  logic        tick;
  logic [3:0]  tick_count;
  logic        done;
  logic        busy;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Event logs (cycle numbers), filled by the monitor
  int w_addr[$], w_data[$], w_cyc[$];
  int tk_cyc[$], dn_cyc[$], irq_cyc[$], ce_cyc[$];
  logic irq_prev = 1'b0;

  always #5 clk = ~clk;

  timer_tick_sequencer #(.TICK_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .cfg_period(cfg_period), .tick_limit(tick_limit),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_irq(tmr_irq), .tick(tick), .tick_count(tick_count),
    .done(done), .busy(busy), .cfg_err(cfg_err)
  );

  // Behavioural interval timer: counts period+1 clocks per timeout, TO sticky until status write
  logic [31:0] t_per, t_cnt;
  logic        t_run, t_to, t_ito;
  assign tmr_irq = t_to & t_ito;

  always @(posedge clk) begin
    if (!reset_n) begin
      t_per <= 0; t_cnt <= 0; t_run <= 0; t_to <= 0; t_ito <= 0;
    end else if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_ito <= tmr_writedata[0];
          if (tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
          else if (tmr_writedata[3]) t_run <= 1'b0;
        end
        3'd2: begin t_per[15:0]  <= tmr_writedata; t_cnt <= {t_per[31:16], tmr_writedata}; end
        3'd3: begin t_per[31:16] <= tmr_writedata; t_cnt <= {tmr_writedata, t_per[15:0]}; end
        default: ;
      endcase
    end else if (t_run) begin
      if (t_cnt == 0) begin t_to <= 1'b1; t_cnt <= t_per; end
      else t_cnt <= t_cnt - 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples mid-cycle
  always @(negedge clk) begin
    if (tmr_chipselect && !tmr_write_n) begin
      w_addr.push_back(int'(tmr_address));
      w_data.push_back(int'(tmr_writedata));
      w_cyc.push_back(cyc);
    end
    if (tick)    tk_cyc.push_back(cyc);
    if (done)    dn_cyc.push_back(cyc);
    if (cfg_err) ce_cyc.push_back(cyc);
    if (tmr_irq && !irq_prev) irq_cyc.push_back(cyc);
    irq_prev = tmr_irq;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    w_addr = {}; w_data = {}; w_cyc = {};
    tk_cyc = {}; dn_cyc = {}; irq_cyc = {}; ce_cyc = {};
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout busy=%0b required 0", busy);
    end
  endtask

  task automatic pulse_start(input int period, input int limit, output int c);
    cfg_period = period; tick_limit = 4'(limit); start = 1'b1; c = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; stop = 1'b0; cfg_period = 32'd5; tick_limit = 4'd2;
    repeat (3) step();
    checks++;
    if ({tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, tick, done, busy, cfg_err}
        !== {3'd0, 1'b0, 1'b1, 16'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_outputs got a=%0d cs=%0b wn=%0b d=%h t=%0b dn=%0b b=%0b ce=%0b",
               tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, tick, done, busy, cfg_err);
    end
    checks++;
    if (tick_count !== 4'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", tick_count);
    end
    start = 1'b0; reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic(input int period, input int limit);
    int c;
    int ea[$], ed[$];
    logic [31:0] p;
    p = period;
    clear_logs();
    pulse_start(period, limit, c);
    wait_idle(limit * (period + 8) + 50);
    step(); step();
    ea = {2, 3, 1}; ed = {int'(p[15:0]), int'(p[31:16]), 7};
    for (int i = 0; i < limit; i++) begin ea.push_back(0); ed.push_back(0); end
    ea.push_back(1); ed.push_back(8);
    checks++;
    if (w_addr.size() != ea.size()) begin
      errors++; $display("FAIL basic_nwrites got %0d want %0d", w_addr.size(), ea.size());
    end
    for (int i = 0; i < ea.size() && i < w_addr.size(); i++) begin
      checks++;
      if (w_addr[i] != ea[i] || w_data[i] != ed[i]) begin
        errors++;
        $display("FAIL basic_write%0d got (%0d,%h) want (%0d,%h)", i, w_addr[i], w_data[i], ea[i], ed[i]);
      end
    end
    for (int i = 0; i < 3 && i < w_cyc.size(); i++) begin
      checks++;
      if (w_cyc[i] != c + 1 + i) begin
        errors++; $display("FAIL cfg_write_cycle%0d got %0d want %0d", i, w_cyc[i], c + 1 + i);
      end
    end
    checks++;
    if (tk_cyc.size() != limit || irq_cyc.size() != limit) begin
      errors++; $display("FAIL basic_ticks got %0d irqs %0d want %0d", tk_cyc.size(), irq_cyc.size(), limit);
    end
    for (int i = 0; i < tk_cyc.size() && i < irq_cyc.size() && 3 + i < w_cyc.size(); i++) begin
      checks++;
      if (tk_cyc[i] != irq_cyc[i] + 1 || w_cyc[3 + i] != tk_cyc[i]) begin
        errors++;
        $display("FAIL tick_latency%0d tick %0d clr %0d want irq+1=%0d", i, tk_cyc[i], w_cyc[3 + i], irq_cyc[i] + 1);
      end
    end
    checks++;
    if (dn_cyc.size() != 1) begin
      errors++; $display("FAIL done_count got %0d want 1", dn_cyc.size());
    end else if (tk_cyc.size() == limit) begin
      checks++;
      if (dn_cyc[0] != tk_cyc[limit - 1] + 2 || w_cyc[w_cyc.size() - 1] != dn_cyc[0]) begin
        errors++;
        $display("FAIL done_timing done %0d stop %0d want %0d", dn_cyc[0], w_cyc[w_cyc.size() - 1], tk_cyc[limit - 1] + 2);
      end
    end
    checks++;
    if (tick_count !== 4'(limit) || busy !== 1'b0) begin
      errors++; $display("FAIL basic_final count %0d busy %0b want %0d 0", tick_count, busy, limit);
    end
  endtask

  task automatic test_wrap();
    int c, n;
    do_reset(); clear_logs();
    pulse_start(4, 0, c);
    n = 0;
    while (tk_cyc.size() < 17 && n < 400) begin step(); n++; end
    checks++;
    if (tk_cyc.size() != 17) begin
      errors++; $display("FAIL wrap_timeout got %0d ticks want 17", tk_cyc.size());
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(20);
    checks++;
    if (tick_count !== 4'd1 || dn_cyc.size() != 0 || tk_cyc.size() != 17) begin
      errors++;
      $display("FAIL wrap_count got %0d done %0d ticks %0d want 1 0 17", tick_count, dn_cyc.size(), tk_cyc.size());
    end
    checks++;
    if (w_addr[w_addr.size() - 1] != 1 || w_data[w_data.size() - 1] != 8 ||
        w_cyc[w_cyc.size() - 1] != tk_cyc[tk_cyc.size() - 1] + 1 || w_addr[w_addr.size() - 2] != 0) begin
      errors++;
      $display("FAIL wrap_stop_write got (%0d,%h)@%0d want (1,8)@%0d", w_addr[w_addr.size() - 1],
               w_data[w_data.size() - 1], w_cyc[w_cyc.size() - 1], tk_cyc[tk_cyc.size() - 1] + 1);
    end
  endtask

  task automatic test_abort_run();
    int c, c2, n;
    do_reset(); clear_logs();
    pulse_start($urandom_range(6, 20), 0, c);
    n = 0;
    while (tk_cyc.size() < 2 && n < 200) begin step(); n++; end
    step(); step();
    c2 = cyc;
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(20);
    checks++;
    if (w_cyc[w_cyc.size() - 1] != c2 + 1 || w_addr[w_addr.size() - 1] != 1 || w_data[w_data.size() - 1] != 8) begin
      errors++;
      $display("FAIL abort_write got (%0d,%h)@%0d want (1,8)@%0d", w_addr[w_addr.size() - 1],
               w_data[w_data.size() - 1], w_cyc[w_cyc.size() - 1], c2 + 1);
    end
    checks++;
    if (tick_count !== 4'd2 || dn_cyc.size() != 0 || tk_cyc.size() != 2) begin
      errors++; $display("FAIL abort_hold count %0d done %0d want 2 0", tick_count, dn_cyc.size());
    end
  endtask

  task automatic test_stop_irq();
    int c, c2, n, nclr;
    do_reset(); clear_logs();
    pulse_start($urandom_range(4, 12), 0, c);
    n = 0;
    while (!tmr_irq && n < 100) begin step(); n++; end
    c2 = cyc;
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(20);
    nclr = 0;
    foreach (w_addr[i]) if (w_addr[i] == 0) nclr++;
    checks++;
    if (tk_cyc.size() != 0 || nclr != 0 || tick_count !== 4'd0) begin
      errors++; $display("FAIL stop_irq_tick ticks %0d clears %0d count %0d want 0", tk_cyc.size(), nclr, tick_count);
    end
    checks++;
    if (w_addr.size() != 4 || w_cyc[w_cyc.size() - 1] != c2 + 1 || w_data[w_data.size() - 1] != 8) begin
      errors++; $display("FAIL stop_irq_write nwrites %0d last@%0d want 4 @%0d", w_addr.size(), w_cyc[w_cyc.size() - 1], c2 + 1);
    end
  endtask

  task automatic test_rejected_start();
    int c;
    do_reset(); clear_logs();
    pulse_start(0, 3, c);
    repeat (5) step();
    checks++;
    if (ce_cyc.size() != 1 || w_addr.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reject cfg_err %0d writes %0d busy %0b want 1 0 0", ce_cyc.size(), w_addr.size(), busy);
    end else begin
      checks++;
      if (ce_cyc[0] != c + 1) begin
        errors++; $display("FAIL reject_cycle got %0d want %0d", ce_cyc[0], c + 1);
      end
    end
    pulse_start(7, 2, c);
    step();
    cfg_period = 0; tick_limit = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    cfg_period = 5; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(100);
    checks++;
    if (ce_cyc.size() != 1 || tk_cyc.size() != 2 || tick_count !== 4'd2 || w_addr.size() != 6 || w_data[0] != 7) begin
      errors++;
      $display("FAIL busy_start cfg_err %0d ticks %0d count %0d writes %0d want 1 2 2 6",
               ce_cyc.size(), tk_cyc.size(), tick_count, w_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset(); clear_logs();
    pulse_start(9, 3, c);
    step();
    checks++;
    if (tmr_address !== 3'd3 || tmr_write_n !== 1'b0) begin
      errors++; $display("FAIL mid_wrph got addr %0d wn %0b want 3 0", tmr_address, tmr_write_n);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if ({tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, tick, tick_count, done, busy, cfg_err}
        !== {3'd0, 1'b0, 1'b1, 16'd0, 1'b0, 4'd0, 3'b000}) begin
      errors++;
      $display("FAIL mid_reset got a=%0d cs=%0b wn=%0b busy=%0b", tmr_address, tmr_chipselect, tmr_write_n, busy);
    end
    reset_n = 1'b1;
    step();
    test_basic(9, 3);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_period = 0; tick_limit = 0;
    test_reset();
    do_reset();
    test_basic(9, 3);
    for (int k = 0; k < 4; k++) begin
      do_reset();
      test_basic($urandom_range(4, 30), $urandom_range(1, 5));
    end
    test_wrap();
    test_abort_run();
    test_stop_irq();
    test_rejected_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
